dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-ported, byte-addressed, big-endian data memory. It shares the memory between requester A (pipeline load/store unit) and requester B (debug/DMA loader). It checks alignment and holds memory controls stable for a fixed number of cycles. It returns one-cycle acknowledgements with read data or an error flag. It sits between the requesters and the memory's address/write_data/MemRead/MemWrite/DataSize/sign/read_data port.

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported data memory.
// Alternates grants on ties, rejects misaligned accesses and holds memory controls for MEM_LATENCY cycles.
module dmem_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        a_write,
  input  logic [1:0]  a_size,
  input  logic        a_sign,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_write,
  input  logic [1:0]  b_size,
  input  logic        b_sign,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [1:0]  mem_DataSize,
  output logic        mem_sign,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t        state;
  logic [CW-1:0] count;
  logic          last_b;
  logic          win_b;

  logic          grant_a;
  logic          grant_b;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_write;
  logic [1:0]    sel_size;
  logic          sel_sign;
  logic          sel_illegal;

  // On a tie the requester that did not get the previous grant wins.
  always_comb begin
    grant_a     = a_req & (~b_req | last_b);
    grant_b     = b_req & ~grant_a;
    sel_addr    = grant_b ? b_addr  : a_addr;
    sel_wdata   = grant_b ? b_wdata : a_wdata;
    sel_write   = grant_b ? b_write : a_write;
    sel_size    = grant_b ? b_size  : a_size;
    sel_sign    = grant_b ? b_sign  : a_sign;
    sel_illegal = (sel_size == 2'b00) ||
                  ((sel_size == 2'b10) && sel_addr[0]) ||
                  ((sel_size == 2'b11) && (sel_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      last_b         <= 1'b1;
      win_b          <= 1'b0;
      a_ack          <= 1'b0;
      b_ack          <= 1'b0;
      a_err          <= 1'b0;
      b_err          <= 1'b0;
      a_rdata        <= '0;
      b_rdata        <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_MemRead    <= 1'b0;
      mem_MemWrite   <= 1'b0;
      mem_DataSize   <= 2'b00;
      mem_sign       <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            win_b <= grant_b;
            if (sel_illegal) begin
              // Rejected without ever touching the memory strobes.
              state <= RESPOND;
              if (grant_b) begin
                b_ack <= 1'b1;
                b_err <= 1'b1;
              end else begin
                a_ack <= 1'b1;
                a_err <= 1'b1;
              end
            end else begin
              state          <= ACCESS;
              count          <= CW'(MEM_LATENCY - 1);
              mem_address    <= sel_addr;
              mem_write_data <= sel_wdata;
              mem_MemRead    <= ~sel_write;
              mem_MemWrite   <= sel_write;
              mem_DataSize   <= sel_size;
              mem_sign       <= sel_sign;
            end
          end
        end
        ACCESS: begin
          if (count == '0) begin
            state        <= RESPOND;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_DataSize <= 2'b00;
            if (win_b) begin
              b_ack <= 1'b1;
              b_err <= 1'b0;
              if (mem_MemRead) b_rdata <= mem_read_data;
            end else begin
              a_ack <= 1'b1;
              a_err <= 1'b0;
              if (mem_MemRead) a_rdata <= mem_read_data;
            end
          end else begin
            count <= count - CW'(1);
          end
        end
        RESPOND: begin
          state  <= IDLE;
          last_b <= win_b;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural big-endian memory, request drivers,
// and an ack monitor that pops expected responses from a queue.
module tb_dmem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic        a_write, b_write;
  logic [1:0]  a_size, b_size;
  logic        a_sign, b_sign;
  logic        a_ack, b_ack, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_MemRead, mem_MemWrite, mem_sign;
  logic [1:0]  mem_DataSize;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  // {check_rdata, id (1=B), err, rdata}
  logic [34:0] exp_q[$];

  dmem_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_write(a_write),
    .a_size(a_size), .a_sign(a_sign), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_write(b_write),
    .b_size(b_size), .b_sign(b_sign), .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_DataSize(mem_DataSize), .mem_sign(mem_sign),
    .mem_read_data(mem_read_data), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem_b [0:255];
  logic       mem_loaded = 1'b0;
  logic [7:0] ra;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
      mem_b[13]  <= 8'h80;
      mem_loaded <= 1'b1;
    end else if (mem_MemWrite) begin
      case (mem_DataSize)
        2'b11: begin
          mem_b[mem_address[7:0]]         <= mem_write_data[31:24];
          mem_b[mem_address[7:0] + 8'd1]  <= mem_write_data[23:16];
          mem_b[mem_address[7:0] + 8'd2]  <= mem_write_data[15:8];
          mem_b[mem_address[7:0] + 8'd3]  <= mem_write_data[7:0];
        end
        2'b10: begin
          mem_b[mem_address[7:0]]         <= mem_write_data[15:8];
          mem_b[mem_address[7:0] + 8'd1]  <= mem_write_data[7:0];
        end
        2'b01: mem_b[mem_address[7:0]]    <= mem_write_data[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    ra = mem_address[7:0];
    mem_read_data = 32'h0;
    if (mem_MemRead) begin
      case (mem_DataSize)
        2'b11: mem_read_data = {mem_b[ra], mem_b[ra + 8'd1], mem_b[ra + 8'd2], mem_b[ra + 8'd3]};
        2'b10: mem_read_data = {{16{mem_sign & mem_b[ra][7]}}, mem_b[ra], mem_b[ra + 8'd1]};
        2'b01: mem_read_data = {{24{mem_sign & mem_b[ra][7]}}, mem_b[ra]};
        default: mem_read_data = 32'h0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          run = 0;
  int          strobe_cycles = 0;
  logic [68:0] snap;
  logic [68:0] cur;
  logic [34:0] e;
  logic        mid;
  logic        got_err;
  logic [31:0] got_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (a_ack && b_ack) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dual_ack: got a_ack=1 b_ack=1, required at most one");
      end else if (a_ack || b_ack) begin
        mid     = b_ack;
        got_err = b_ack ? b_err : a_err;
        got_rd  = b_ack ? b_rdata : a_rdata;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: got ack from %s, required none", mid ? "B" : "A");
        end else begin
          e = exp_q.pop_front();
          if (mid != e[33] || got_err != e[32] || (e[34] && got_rd != e[31:0])) begin
            n_fail++;
            $display("FAIL ack_response: got id=%0d err=%0b rdata=%08h, required id=%0d err=%0b rdata=%08h",
                     mid, got_err, got_rd, e[33], e[32], e[31:0]);
          end
        end
      end

      cur = {mem_address, mem_write_data, mem_MemRead, mem_MemWrite, mem_DataSize, mem_sign};
      if (mem_MemRead && mem_MemWrite) begin
        n_cmp++;
        n_fail++;
        $display("FAIL strobe_overlap: got MemRead=1 MemWrite=1, required at most one");
      end
      if (mem_MemRead || mem_MemWrite) begin
        strobe_cycles++;
        if (run > 0 && cur != snap) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mem_stable: got %h, required %h", cur, snap);
        end
        snap = cur;
        run++;
      end else if (run > 0) begin
        n_cmp++;
        if (run != L) begin
          n_fail++;
          $display("FAIL strobe_length: got %0d cycles, required %0d", run, L);
        end
        run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [34:0] mk(input bit chk, input bit id, input bit err, input logic [31:0] rd);
    return {chk, id, err, rd};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", name, got, req);
    end
  endtask

  task automatic issue(input bit is_b, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit wr, input logic [1:0] size, input bit sgn,
                       input int exp_lat, input string name);
    int lat;
    bit got;
    @(posedge clk);
    #1;
    if (is_b) begin
      b_addr = addr; b_wdata = wdata; b_write = wr; b_size = size; b_sign = sgn; b_req = 1'b1;
    end else begin
      a_addr = addr; a_wdata = wdata; a_write = wr; a_size = size; a_sign = sgn; a_req = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      got = is_b ? b_ack : a_ack;
    end
    if (is_b) b_req = 1'b0;
    else      a_req = 1'b0;
    n_cmp++;
    if (!got || lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles (ack seen=%0b), required %0d", name, lat, got, exp_lat);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, {29'h0, a_ack, b_ack, busy}, 32'h0);
    check({name, "_errs"}, {30'h0, a_err, b_err}, 32'h0);
    check({name, "_a_rdata"}, a_rdata, 32'h0);
    check({name, "_b_rdata"}, b_rdata, 32'h0);
    check({name, "_mem_addr"}, mem_address, 32'h0);
    check({name, "_mem_wdata"}, mem_write_data, 32'h0);
    check({name, "_mem_ctl"}, {26'h0, mem_MemRead, mem_MemWrite, mem_DataSize, mem_sign, 1'b0}, 32'h0);
    check({name, "_state"}, {30'h0, dbg_state}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  int sc0;
  int acks;
  int cyc;

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_addr = '0; a_wdata = '0; a_write = 1'b0; a_size = 2'b00; a_sign = 1'b0;
    b_req = 1'b0; b_addr = '0; b_wdata = '0; b_write = 1'b0; b_size = 2'b00; b_sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // A-only store then load back
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0));
    issue(1'b0, 32'd4, 32'h01234567, 1'b1, 2'b11, 1'b0, L + 1, "a_store_word");
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h01234567));
    issue(1'b0, 32'd4, 32'h0, 1'b0, 2'b11, 1'b0, L + 1, "a_load_word");
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h00004567));
    issue(1'b0, 32'd6, 32'h0, 1'b0, 2'b10, 1'b1, L + 1, "a_load_half");

    // B byte loads, signed and unsigned
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'hFFFFFF80));
    issue(1'b1, 32'd13, 32'h0, 1'b0, 2'b01, 1'b1, L + 1, "b_load_byte_s");
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h00000080));
    issue(1'b1, 32'd13, 32'h0, 1'b0, 2'b01, 1'b0, L + 1, "b_load_byte_u");

    // Illegal requests: single-cycle error, no strobes
    sc0 = strobe_cycles;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0));
    issue(1'b0, 32'd6, 32'h0, 1'b0, 2'b11, 1'b0, 1, "a_word_misaligned");
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0));
    issue(1'b0, 32'd11, 32'h0, 1'b1, 2'b10, 1'b0, 1, "a_half_misaligned");
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0));
    issue(1'b0, 32'd0, 32'h0, 1'b0, 2'b00, 1'b0, 1, "a_size00");
    @(negedge clk);
    check("illegal_no_strobes", strobe_cycles - sc0, 32'h0);
    check("a_rdata_held", a_rdata, 32'h00004567);

    // B arrives while A is in ACCESS
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h01234567));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h00000080));
    fork
      issue(1'b0, 32'd4, 32'h0, 1'b0, 2'b11, 1'b0, L + 1, "b2b_a");
      begin
        repeat (2) @(posedge clk);
        issue(1'b1, 32'd13, 32'h0, 1'b0, 2'b01, 1'b0, 2 * L + 1, "b2b_b");
      end
    join

    // Reset in the middle of a store
    @(posedge clk);
    #1;
    a_addr = 32'd20; a_wdata = 32'hDEADBEEF; a_write = 1'b1; a_size = 2'b11; a_sign = 1'b0;
    a_req = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_memwrite_before", {31'h0, mem_MemWrite}, 32'h1);
    #6;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    a_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midreset_no_write", {mem_b[20], mem_b[21], mem_b[22], mem_b[23]}, 32'h0);

    // Both requesters held continuously: grants alternate starting with A
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h01234567));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'hFFFFFF80));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h01234567));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'hFFFFFF80));
    a_addr = 32'd4;  a_write = 1'b0; a_size = 2'b11; a_sign = 1'b0;
    b_addr = 32'd13; b_write = 1'b0; b_size = 2'b01; b_sign = 1'b1;
    a_req = 1'b1;
    b_req = 1'b1;
    acks = 0;
    cyc = 0;
    while (acks < 4 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (a_ack || b_ack) acks++;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("tie_ack_count", acks, 32'd4);
    check("tie_cycles", cyc, 32'd4 * (L + 2) - 1);

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'h0);
    check("idle_at_end", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
